fifo_1d_downsizer: RTL



---
 rtl/fifo_1d_downsizer.sv | 129 ++++++++++++
 1 files changed

// File: rtl/fifo_1d_downsizer.sv
// fifo_1d_downsizer: wide-to-narrow stream converter. Each accepted beat
// carries 1..N OUT_W-bit chunks, emitted one per cycle, most-significant
// chunk first. Define FIFO_1D_DOWNSIZER_SKID_EN to add a second (skid)
// entry that registers a_ready and decouples it from b_ready.
module fifo_1d_downsizer #(
  parameter  int IN_W  = 64,
  parameter  int OUT_W = 22,
  localparam int N     = (IN_W + OUT_W - 1) / OUT_W,
  localparam int CNT_W = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  a_data,
  input  logic [CNT_W-1:0] a_count,
  input  logic             a_last,
  input  logic             a_valid,
  output logic             a_ready,
  output logic [OUT_W-1:0] b_data,
  output logic             b_last,
  output logic             b_valid,
  input  logic             b_ready
);

  localparam int               PAD_W = N * OUT_W;
  localparam logic [CNT_W-1:0] N_C   = CNT_W'(N);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  // Head entry
  logic [IN_W-1:0]  r_data;
  logic [CNT_W-1:0] r_level;
  logic             r_last;

  logic [CNT_W-1:0] w_count;
  logic             w_take;
  logic             w_accept;
  logic             w_head_free;
  logic             w_a_ready;
  logic [PAD_W-1:0] w_pad;
  logic [OUT_W-1:0] w_b_data;

  // Counts above N are clamped; skipped when the count field cannot exceed N
  if (((2 ** CNT_W) - 1) > N) begin : g_clamp
    assign w_count = (a_count > N_C) ? N_C : a_count;
  end else begin : g_noclamp
    assign w_count = a_count;
  end

  assign w_take      = (r_level != '0) && b_ready;
  assign w_accept    = a_valid && w_a_ready;
  // Head can take a new beat this edge: empty, or its final chunk leaves now
  assign w_head_free = (r_level == '0) || ((r_level == ONE) && w_take);

`ifdef FIFO_1D_DOWNSIZER_SKID_EN
  // Skid entry; only non-empty beats are ever stored here
  logic [IN_W-1:0]  r_s_data;
  logic [CNT_W-1:0] r_s_count;
  logic             r_s_last;
  logic             r_s_full;

  assign w_a_ready = !r_s_full;

  // Head/skid update: skid drains into the head first so beat order holds
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_data    <= '0;
      r_level   <= '0;
      r_last    <= 1'b0;
      r_s_data  <= '0;
      r_s_count <= '0;
      r_s_last  <= 1'b0;
      r_s_full  <= 1'b0;
    end else if (w_head_free && r_s_full) begin
      r_data   <= r_s_data;
      r_level  <= r_s_count;
      r_last   <= r_s_last;
      r_s_full <= 1'b0;
    end else if (w_head_free && w_accept) begin
      r_data  <= a_data;
      r_level <= w_count;
      r_last  <= a_last && (w_count != '0);
    end else begin
      if (w_take) begin
        r_level <= r_level - ONE;
      end
      if (w_accept && (w_count != '0)) begin
        r_s_data  <= a_data;
        r_s_count <= w_count;
        r_s_last  <= a_last;
        r_s_full  <= 1'b1;
      end
    end
  end
`else
  assign w_a_ready = w_head_free;

  // Head update: a refill overwrites the finishing beat instead of decrementing
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_level <= '0;
      r_last  <= 1'b0;
    end else if (w_head_free && w_accept) begin
      r_data  <= a_data;
      r_level <= w_count;
      r_last  <= a_last && (w_count != '0);
    end else if (w_take) begin
      r_level <= r_level - ONE;
    end
  end
`endif

  assign w_pad = PAD_W'(r_data);

  // Select chunk[level-1]; zero when the head is empty
  always_comb begin
    w_b_data = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (r_level == CNT_W'(k + 1)) begin
        w_b_data = w_pad[k*OUT_W +: OUT_W];
      end
    end
  end

  assign a_ready = w_a_ready;
  assign b_data  = w_b_data;
  assign b_valid = (r_level != '0);
  assign b_last  = r_last && (r_level == ONE);

endmodule
